// File: rtl/exp_sum_buffer.sv
// exp_sum_buffer: captures one vector of Q0.16 exp values and accumulates
// their sum for the softmax divide stage. Optional macro: EXP_SUM_ROUND_EN.
module exp_sum_buffer #(
   parameter int data_size = 32,
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = 4
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [ADDR_W:0]       len_i,
   input  logic                  exp_valid_i,
   input  logic [data_size-1:0]  exp_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_W-1:0]     rd_addr_i,
   output logic [15:0]           rd_data_o,
   output logic                  rd_valid_o,
   output logic [16+ADDR_W-1:0]  sum_o,
   output logic                  sum_valid_o,
   output logic                  busy_o,
   output logic                  err_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_W:0]       r_len;
   logic [ADDR_W:0]       r_cnt;
   logic [16+ADDR_W-1:0]  r_sum;
   logic                  r_err;
   logic                  r_rd_valid;
   logic [15:0]           r_rd_data;
   logic [15:0]           r_buf [DEPTH];

   logic [15:0]           w_v;
   logic                  w_len_ok;
   logic                  w_idle_done;
   logic                  w_start_ok;
   logic                  w_acc;
   logic                  w_last;
   logic                  w_in_done;
   logic                  w_addr_ok;
   logic                  w_rd_ok;
   logic                  w_err;
   logic                  w_unused;

`ifdef EXP_SUM_ROUND_EN
   logic [16:0]           w_rnd;
   // round half up on bit 15, saturate at 0xFFFF
   assign w_rnd = {1'b0, exp_data_i[31:16]} + 17'(exp_data_i[15]);
   assign w_v   = w_rnd[16] ? 16'hFFFF : w_rnd[15:0];
`else
   assign w_v   = exp_data_i[31:16];
`endif

   assign w_unused    = ^exp_data_i;
   assign w_len_ok    = (len_i != '0) && (len_i <= LP_DEPTH);
   assign w_idle_done = (r_state != S_ACCUM);
   assign w_in_done   = (r_state == S_DONE);
   assign w_start_ok  = start_i & w_len_ok & w_idle_done;
   assign w_acc       = exp_valid_i & (r_state == S_ACCUM);
   assign w_last      = w_acc & (r_cnt == (r_len - LP_ONE));
   assign w_addr_ok   = ({1'b0, rd_addr_i} < r_len);
   assign w_rd_ok     = rd_en_i & w_in_done & w_addr_ok;
   assign w_err       = (start_i & (~w_idle_done | ~w_len_ok))
                      | (exp_valid_i & w_idle_done)
                      | (rd_en_i & w_in_done & ~w_addr_ok);

   // state register
   always_ff @(posedge clock_i) begin
      if (reset_i) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_start_ok) w_next = S_ACCUM;
         S_ACCUM: if (w_last)     w_next = S_DONE;
         S_DONE:  if (w_start_ok) w_next = S_ACCUM;
         default: w_next = S_IDLE;
      endcase
   end

   // count, running sum, sticky error and read port
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_len      <= '0;
         r_cnt      <= '0;
         r_sum      <= '0;
         r_err      <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_err      <= r_err | w_err;
         r_rd_valid <= w_rd_ok;
         if (w_rd_ok) r_rd_data <= r_buf[rd_addr_i];
         if (w_start_ok) begin
            r_len <= len_i;
            r_cnt <= '0;
            r_sum <= '0;
         end else if (w_acc) begin
            r_cnt <= r_cnt + LP_ONE;
            r_sum <= r_sum + (16+ADDR_W)'(w_v);
         end
      end
   end

   // sample storage, not reset
   always_ff @(posedge clock_i) begin
      if (w_acc) r_buf[r_cnt[ADDR_W-1:0]] <= w_v;
   end

   assign rd_data_o   = r_rd_data;
   assign rd_valid_o  = r_rd_valid;
   assign sum_o       = r_sum;
   assign sum_valid_o = w_in_done;
   assign busy_o      = (r_state == S_ACCUM);
   assign err_o       = r_err;

endmodule

// File: tb/tb_exp_sum_buffer.sv
// tb_exp_sum_buffer: directed scenarios for exp_sum_buffer with a
// scoreboard of expected sums and read data.
module tb_exp_sum_buffer;

   localparam int AW = 4;

`ifdef EXP_SUM_ROUND_EN
   localparam logic [15:0] RND = 16'h1235;
`else
   localparam logic [15:0] RND = 16'h1234;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [AW:0]    len = '0;
   logic           ev = 1'b0;
   logic [31:0]    ed = '0;
   logic           rd_en = 1'b0;
   logic [AW-1:0]  rd_addr = '0;
   logic [15:0]    rd_data;
   logic           rd_valid;
   logic [19:0]    sum;
   logic           sum_valid;
   logic           busy;
   logic           err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [19:0] sum_q [$];
   logic [15:0] rd_q  [$];

   exp_sum_buffer dut (
      .clock_i     (clk),
      .reset_i     (rst),
      .start_i     (start),
      .len_i       (len),
      .exp_valid_i (ev),
      .exp_data_i  (ed),
      .rd_en_i     (rd_en),
      .rd_addr_i   (rd_addr),
      .rd_data_o   (rd_data),
      .rd_valid_o  (rd_valid),
      .sum_o       (sum),
      .sum_valid_o (sum_valid),
      .busy_o      (busy),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic do_start(input logic [AW:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d);
      ev = 1'b1;
      ed = d;
      tick();
      ev = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en   = 1'b0;
   endtask

   // monitor: compare sum on sum_valid rise, data on each rd_valid
   logic sv_prev = 1'b0;
   always @(negedge clk) begin
      if (sum_valid && !sv_prev) begin
         if (sum_q.size() == 0) chk("sum_unexpected", 32'(sum_valid), 32'd0);
         else chk("sum", 32'(sum), 32'(sum_q.pop_front()));
      end
      if (rd_valid) begin
         if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_valid), 32'd0);
         else chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
      end
      sv_prev = sum_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();
      @(negedge clk);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_sum_valid", 32'(sum_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      // 4-element vector, back-to-back
      do_start(5'd4);
      @(negedge clk);
      chk("busy_after_start", 32'(busy), 32'd1);
      sum_q.push_back(20'h18581);
      send(32'hFFFFFFFF);
      send(32'h5E2D0000);
      send(32'h22A50000);
      send(32'h04B00000);
      @(negedge clk);
      chk("v4_sum_valid", 32'(sum_valid), 32'd1);
      chk("v4_busy", 32'(busy), 32'd0);
      rd_q.push_back(16'h5E2D);
      rd(4'd1);
      rd_q.push_back(16'h04B0);
      rd(4'd3);
      @(negedge clk);
      chk("rd_ok_err", 32'(err), 32'd0);
      rd(4'd5);
      @(negedge clk);
      chk("rd_oob_err", 32'(err), 32'd1);
      chk("rd_oob_valid", 32'(rd_valid), 32'd0);

      // full depth with random gaps
      do_reset();
      do_start(5'd16);
      sum_q.push_back(20'hFFFF0);
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         @(negedge clk);
         chk("full_busy", 32'(busy), 32'd1);
         send(32'hFFFFFFFF);
      end
      @(negedge clk);
      chk("full_busy_end", 32'(busy), 32'd0);
      chk("full_err", 32'(err), 32'd0);

      // exp_valid in IDLE
      do_reset();
      send(32'h40000000);
      @(negedge clk);
      chk("idle_ev_err", 32'(err), 32'd1);
      chk("idle_ev_sum", 32'(sum), 32'd0);

      // illegal lengths
      do_reset();
      do_start(5'd0);
      @(negedge clk);
      chk("len0_busy", 32'(busy), 32'd0);
      chk("len0_err", 32'(err), 32'd1);
      do_reset();
      do_start(5'd17);
      @(negedge clk);
      chk("len17_busy", 32'(busy), 32'd0);
      chk("len17_err", 32'(err), 32'd1);

      // start in ACCUM ignored; sample in the same cycle still taken
      do_reset();
      do_start(5'd2);
      sum_q.push_back(20'h03000);
      start = 1'b1;
      len   = 5'd1;
      send(32'h10000000);
      start = 1'b0;
      @(negedge clk);
      chk("accum_start_busy", 32'(busy), 32'd1);
      chk("accum_start_err", 32'(err), 32'd1);
      send(32'h20000000);
      @(negedge clk);
      chk("accum_start_done", 32'(sum_valid), 32'd1);

      // reset mid-vector
      do_reset();
      do_start(5'd4);
      send(32'h11110000);
      send(32'h22220000);
      do_reset();
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_sum", 32'(sum), 32'd0);
      chk("mid_rst_sv", 32'(sum_valid), 32'd0);
      do_start(5'd1);
      sum_q.push_back(20'h05E2D);
      send(32'h5E2D0000);

      // rounding
      do_start(5'd2);
      sum_q.push_back(20'(RND) + 20'h0FFFF);
      send(32'h12348000);
      send(32'hFFFF8000);
      rd_q.push_back(RND);
      rd(4'd0);
      rd_q.push_back(16'hFFFF);
      rd(4'd1);

      // start in DONE with a read in the same cycle
      start   = 1'b1;
      len     = 5'd1;
      rd_en   = 1'b1;
      rd_addr = 4'd1;
      rd_q.push_back(16'hFFFF);
      tick();
      start = 1'b0;
      rd_en = 1'b0;
      @(negedge clk);
      chk("done_start_sv", 32'(sum_valid), 32'd0);
      chk("done_start_busy", 32'(busy), 32'd1);
      sum_q.push_back(20'h00001);
      send(32'h00010000);
      repeat (3) tick();
      @(negedge clk);
      chk("sum_q_empty", 32'(sum_q.size()), 32'd0);
      chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
      chk("final_err", 32'(err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/exp_sum_buffer.md
# exp_sum_buffer

Stage directly downstream of the LUT-based exponent unit in the softmax compute path. Each valid exp result for one input vector is captured into an internal buffer, and a running sum of the vector's exps is kept. When the last element has arrived, the block presents the denominator sum for the divide stage. The buffered exps stay readable by index until the next vector starts.

## Interface
- data_size, 32, width of the incoming exp word.
- DEPTH, 16, maximum vector length; must be a power of two.
- ADDR_W, 4, log2(DEPTH).
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin a new vector; honoured only in IDLE or DONE.
- len_i  in  ADDR_W+1  vector length, sampled with start_i; legal range 1..DEPTH.
- exp_valid_i  in  1  exp sample valid; driven from the exp unit's valid output.
- exp_data_i  in  data_size  exp sample; bits [31:16] carry the Q0.16 value (0xFFFF ≈ 1.0).
- rd_en_i  in  1  buffer read request.
- rd_addr_i  in  ADDR_W  buffer index to read.
- rd_data_o  out  16  buffered Q0.16 exp value.
- rd_valid_o  out  1  rd_data_o is valid.
- sum_o  out  16+ADDR_W  sum of the vector's exps, unsigned Q(ADDR_W).16.
- sum_valid_o  out  1  sum_o is final.
- busy_o  out  1  high while accumulating.
- err_o  out  1  sticky protocol-error flag.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE to ACCUM on start_i with a legal len_i. Entering ACCUM latches len_i and clears the count, sum_o and sum_valid_o.
- An illegal start (len_i = 0 or len_i > DEPTH) leaves the state unchanged and sets err_o.
- In ACCUM, each cycle with exp_valid_i high:
  - stores v = exp_data_i[31:16] into buf[cnt];
  - sum_o += v, zero-extended;
  - cnt += 1.
- Gaps between samples are allowed. Back-to-back samples at one per cycle are supported.
- ACCUM to DONE on the accepted sample where cnt = len-1.
- In DONE:
  - sum_o is held stable and sum_valid_o is held high;
  - start_i with a legal len_i goes directly to ACCUM.
- busy_o = (state == ACCUM).
- start_i in ACCUM is ignored and sets err_o.
- exp_valid_i in IDLE or DONE is ignored (no write, no sum change) and sets err_o. This includes the cycle in which start_i is sampled.
- Reads:
  - honoured only in DONE;
  - rd_addr_i >= latched len sets err_o, and rd_valid_o stays 0;
  - a rd_en_i outside DONE is ignored, with no error.
- The sum cannot overflow: DEPTH·0xFFFF fits in 16+ADDR_W bits.
- err_o clears only on reset.

## Timing
- Reset values: state IDLE, cnt 0, sum_o 0, sum_valid_o 0, busy_o 0, rd_valid_o 0, rd_data_o 0, err_o 0. Buffer contents are not reset, and the bench must not check them.
- A reset in any state, including mid-ACCUM, returns to IDLE on the next edge and discards the partial sum.
- busy_o rises the cycle after an accepted start_i.
- sum_valid_o rises the cycle after the last sample is accepted (1-cycle latency). busy_o falls in that same cycle.
- sum_o updates one cycle after each accepted sample.
- Read latency is 1 cycle: rd_en_i in cycle N gives rd_data_o and rd_valid_o in cycle N+1. rd_valid_o is a single-cycle pulse per request. rd_data_o holds its last value otherwise.
- A start_i in DONE drops sum_valid_o on the next edge. A read issued in that same cycle is still served with the old buffer contents.

## Configuration
- EXP_SUM_ROUND_EN defined: v = exp_data_i[31:16] + exp_data_i[15], rounding half up, saturated to 0xFFFF.
- EXP_SUM_ROUND_EN undefined: v = exp_data_i[31:16] (truncation).
- The macro applies equally to the stored value and to the summed value.

## Test plan
- Sum of a 4-element vector: start with len 4, then back-to-back samples 0xFFFFFFFF, 0x5E2D0000, 0x22A50000, 0x04B00000. Required: sum_o = 0x18581 and sum_valid_o high 1 cycle after the 4th sample.
- Buffer readback: in DONE after the first scenario, rd_addr 1 -> rd_data_o 0x5E2D with rd_valid_o high next cycle; rd_addr 5 -> err_o = 1, rd_valid_o = 0.
- Full depth: len 16, sixteen samples of 0xFFFFFFFF with random gaps. Required: sum_o = 0xFFFF0, and busy_o stays high until the 16th sample.
- Protocol errors:
  - exp_valid_i in IDLE -> err_o = 1, sum_o = 0;
  - start with len 0 -> state stays IDLE, err_o = 1;
  - start_i in ACCUM -> ignored.
- Reset mid-vector: reset after 2 of 4 samples -> busy_o = 0 and sum_o = 0. A new start with len 1 and sample 0x5E2D0000 then gives sum_o = 0x5E2D.
- Rounding: sample 0x12348000 -> 0x1235 with EXP_SUM_ROUND_EN, 0x1234 without. Sample 0xFFFF8000 -> 0xFFFF in both builds.
